// File: rtl/dec_3to8_if.sv
// Select/enable inputs and one-hot decoder outputs for dec_3to8.
// Optional macro DEC_3TO8_VLD_EN adds the registered 'vld' output.
interface dec_3to8_if;
    logic a;
    logic b;
    logic c;
    logic in;
    logic d0;
    logic d1;
    logic d2;
    logic d3;
    logic d4;
    logic d5;
    logic d6;
    logic d7;
`ifdef DEC_3TO8_VLD_EN
    logic vld;

    modport master (
        output a, b, c, in,
        input  d0, d1, d2, d3, d4, d5, d6, d7, vld
    );
    modport slave (
        input  a, b, c, in,
        output d0, d1, d2, d3, d4, d5, d6, d7, vld
    );
`else
    modport master (
        output a, b, c, in,
        input  d0, d1, d2, d3, d4, d5, d6, d7
    );
    modport slave (
        input  a, b, c, in,
        output d0, d1, d2, d3, d4, d5, d6, d7
    );
`endif
endinterface

// File: rtl/dec_3to8.sv
// 3-to-8 decoder with active-high enable and flopped one-hot outputs.
// Optional macro DEC_3TO8_VLD_EN adds 'vld', a registered copy of the enable.
module dec_3to8 (
    input  logic        clk,
    input  logic        rst,
    dec_3to8_if.slave   bus
);

    logic [2:0] sel_s;
    logic [7:0] dec_s;
    logic [7:0] dec_r;

    // Decode the select into a one-hot word, gated by the enable.
    always_comb begin
        sel_s = {bus.a, bus.b, bus.c};
        dec_s = 8'h00;
        if (bus.in) begin
            case (sel_s)
                3'd0:    dec_s = 8'h01;
                3'd1:    dec_s = 8'h02;
                3'd2:    dec_s = 8'h04;
                3'd3:    dec_s = 8'h08;
                3'd4:    dec_s = 8'h10;
                3'd5:    dec_s = 8'h20;
                3'd6:    dec_s = 8'h40;
                3'd7:    dec_s = 8'h80;
                default: dec_s = 8'h00;
            endcase
        end else begin
            dec_s = 8'h00;
        end
    end

    // Output flops; reset clears them without waiting for a clock.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dec_r <= 8'h00;
        end else begin
            dec_r <= dec_s;
        end
    end

    assign bus.d0 = dec_r[0];
    assign bus.d1 = dec_r[1];
    assign bus.d2 = dec_r[2];
    assign bus.d3 = dec_r[3];
    assign bus.d4 = dec_r[4];
    assign bus.d5 = dec_r[5];
    assign bus.d6 = dec_r[6];
    assign bus.d7 = dec_r[7];

`ifdef DEC_3TO8_VLD_EN
    logic vld_r;

    // Enable delayed alongside the decoded word so vld marks a one-hot output.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_r <= 1'b0;
        end else begin
            vld_r <= bus.in;
        end
    end

    assign bus.vld = vld_r;
`endif

endmodule

// File: tb/tb_dec_3to8.sv
// Self-checking bench for dec_3to8: directed scenarios plus random stimulus
// compared each cycle against a behavioural decoder model.
module tb_dec_3to8;

    logic clk;
    logic rst;
    int   total;
    int   bad;
    bit   chk_en;

    logic [7:0] exp_d;
    logic       exp_v;
    logic [7:0] got_d;
    logic [2:0] sel;

    dec_3to8_if bus ();

    dec_3to8 dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign got_d = {bus.d7, bus.d6, bus.d5, bus.d4, bus.d3, bus.d2, bus.d1, bus.d0};
    assign {bus.a, bus.b, bus.c} = sel;

    task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h expected=%h at %0t", name, got, exp, $time);
        end
    endtask

    // Reference: output word is 2**select when enabled, zero when not or in reset.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            exp_d = 8'h00;
            exp_v = 1'b0;
        end else begin
            exp_d = bus.in ? (8'd1 << int'(sel)) : 8'h00;
            exp_v = bus.in;
        end
    end

    // Every-cycle comparison on the falling edge.
    always @(negedge clk) begin
        if (chk_en) begin
            check("model_d", got_d, exp_d);
`ifdef DEC_3TO8_VLD_EN
            check("model_vld", {7'd0, bus.vld}, {7'd0, exp_v});
`endif
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] lit [8];
        lit[0] = 8'h01; lit[1] = 8'h02; lit[2] = 8'h04; lit[3] = 8'h08;
        lit[4] = 8'h10; lit[5] = 8'h20; lit[6] = 8'h40; lit[7] = 8'h80;
        total  = 0;
        bad    = 0;
        chk_en = 1'b0;

        // Reset held with enable and select active.
        rst    = 1'b1;
        bus.in = 1'b1;
        sel    = 3'b101;
        #3;
        check("reset_async", got_d, 8'h00);
        repeat (2) @(posedge clk);
        #1;
        check("reset_hold", got_d, 8'h00);
`ifdef DEC_3TO8_VLD_EN
        check("reset_vld", {7'd0, bus.vld}, 8'h00);
`endif
        @(negedge clk);
        #1 rst = 1'b0;
        chk_en = 1'b1;

        // Enabled sweep with literal expectations one edge later.
        for (int k = 0; k < 8; k++) begin
            @(posedge clk);
            #1;
            if (k > 0) check("sweep_en", got_d, lit[k-1]);
            #1;
            bus.in = 1'b1;
            sel    = 3'(k);
        end
        @(posedge clk);
        #1 check("sweep_en", got_d, lit[7]);

        // Disabled sweep.
        for (int k = 0; k < 8; k++) begin
            #1;
            bus.in = 1'b0;
            sel    = 3'(k);
            @(posedge clk);
            #1 check("sweep_dis", got_d, 8'h00);
        end

        // Latency: mid-cycle select change is invisible until the next edge.
        #1;
        bus.in = 1'b1;
        sel    = 3'b010;
        @(posedge clk);
        #1 check("lat_first", got_d, 8'h04);
        #2 sel = 3'b110;
        #1 check("lat_hold", got_d, 8'h04);
        @(posedge clk);
        #1 check("lat_next", got_d, 8'h40);

        // Reset between edges while d7 is high.
        #1 sel = 3'b111;
        @(posedge clk);
        #1 check("rst_mid_pre", got_d, 8'h80);
        #2 rst = 1'b1;
        #1 check("rst_mid_async", got_d, 8'h00);
        @(negedge clk);
        #1 rst = 1'b0;
        #1 check("rst_mid_low", got_d, 8'h00);
        @(posedge clk);
        #1 check("rst_mid_rel", got_d, 8'h80);

        // Enable toggling every four clocks on select 3.
        #1 sel = 3'b011;
        for (int k = 0; k < 16; k++) begin
            bus.in = ((k / 4) % 2) == 0;
            @(posedge clk);
            #1 check("toggle", got_d, bus.in ? 8'h08 : 8'h00);
            #1;
        end

        // Random stimulus with occasional asynchronous reset pulses.
        for (int k = 0; k < 300; k++) begin
            @(posedge clk);
            #2;
            bus.in = 1'($urandom_range(0, 1));
            sel    = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 31) == 0) begin
                rst = 1'b1;
                #1 check("rand_rst", got_d, 8'h00);
                @(negedge clk);
                #1 rst = 1'b0;
            end
        end
        @(posedge clk);
        @(negedge clk);
        chk_en = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
